// File: rtl/viterbi_pkg.sv
// Shared Viterbi constants, types and trellis helper.
// Geometry comes from `MAX_STATE_NUM / `RADIX (defaults 256 / 4).
`ifndef MAX_STATE_NUM
`define MAX_STATE_NUM 256
`endif
`ifndef RADIX
`define RADIX 4
`endif

package viterbi_pkg;

  localparam int NSTATE  = `MAX_STATE_NUM;
  localparam int RADIX   = `RADIX;
  localparam int STATE_W = $clog2(NSTATE);
  localparam int DIST_W  = 3;
  localparam int PM_W    = 10;
  localparam int CNT_W   = 16;

  typedef logic [PM_W-1:0]    pm_t;
  typedef logic [DIST_W-1:0]  dist_t;
  typedef logic [1:0]         dec_t;
  typedef logic [STATE_W-1:0] state_t;

  localparam pm_t INIT_PM = pm_t'(2 ** (PM_W - 2));

  // Predecessor p of next-state ns in the shift-register trellis
  function automatic state_t pred_state(
    input state_t ns,
    input dec_t   p
  );
    return {p, ns[STATE_W-1:2]};
  endfunction

endpackage

// File: rtl/acs_unit_if.sv
// Symbol input / metric output bundle of the ACS stage.
// master drives distances, slave is the ACS unit.
interface acs_unit_if;
  import viterbi_pkg::*;

  logic                           i_start;
  logic                           i_valid;
  dist_t [NSTATE-1:0][RADIX-1:0]  i_dist;
  logic                           o_valid;
  dec_t  [NSTATE-1:0]             o_decision;
  pm_t   [NSTATE-1:0]             o_pm;
  logic  [CNT_W-1:0]              o_sym_cnt;
  state_t                         o_best_state;

  modport master (
    output i_start, i_valid, i_dist,
    input  o_valid, o_decision, o_pm,
    input  o_sym_cnt, o_best_state
  );

  modport slave (
    input  i_start, i_valid, i_dist,
    output o_valid, o_decision, o_pm,
    output o_sym_cnt, o_best_state
  );

endinterface

// File: rtl/acs_butterfly.sv
// Radix-4 add-compare-select for one next-state.
// Purely combinational; ties resolve to the lowest predecessor.
module acs_butterfly
  import viterbi_pkg::*;
(
  input  pm_t   [3:0] pm_i,
  input  dist_t [3:0] dist_i,
  output pm_t         pm_o,
  output dec_t        dec_o
);

  pm_t  [3:0] cand;
  pm_t        lo_a, lo_b;
  dec_t       sel_a, sel_b;

  // Pairwise compare; strict < keeps the lower index on ties
  always_comb begin
    for (int p = 0; p < 4; p++)
      cand[p] = pm_i[p] + pm_t'(dist_i[p]);
    if (cand[1] < cand[0]) begin
      lo_a  = cand[1];
      sel_a = 2'd1;
    end else begin
      lo_a  = cand[0];
      sel_a = 2'd0;
    end
    if (cand[3] < cand[2]) begin
      lo_b  = cand[3];
      sel_b = 2'd3;
    end else begin
      lo_b  = cand[2];
      sel_b = 2'd2;
    end
    if (lo_b < lo_a) begin
      pm_o  = lo_b;
      dec_o = sel_b;
    end else begin
      pm_o  = lo_a;
      dec_o = sel_a;
    end
  end

endmodule

// File: rtl/acs_unit.sv
// Radix-4 ACS stage: path-metric update, survivors, renormalisation.
// Optional BEST_STATE_EN adds a registered argmin of the metrics.
module acs_unit
  import viterbi_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  acs_unit_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        fsm_q, fsm_d;
  pm_t  [NSTATE-1:0] pm_q, pm_d;
  pm_t  [NSTATE-1:0] pm_src, pm_init;
  dec_t [NSTATE-1:0] dec_q, dec_d;
  pm_t               pm_new  [NSTATE];
  pm_t               pm_norm [NSTATE];
  dec_t              dec_new [NSTATE];
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic              all_msb;

  // Frame-start metrics: state 0 is the known origin
  always_comb begin
    for (int s = 0; s < NSTATE; s++)
      pm_init[s] = (s == 0) ? '0 : INIT_PM;
  end

  // A start in the same cycle as a symbol feeds initial metrics
  always_comb pm_src = bus.i_start ? pm_init : pm_q;

  for (genvar ns = 0; ns < NSTATE; ns++) begin : g_acs
    pm_t   [3:0] bpm;
    dist_t [3:0] bdist;

    // Gather the four predecessors of this next-state
    always_comb begin
      for (int p = 0; p < 4; p++) begin
        bpm[p]   = pm_src[pred_state(state_t'(ns), dec_t'(p))];
        bdist[p] = bus.i_dist[pred_state(state_t'(ns), dec_t'(p))][ns % RADIX];
      end
    end

    acs_butterfly u_bfly (
      .pm_i   (bpm),
      .dist_i (bdist),
      .pm_o   (pm_new[ns]),
      .dec_o  (dec_new[ns])
    );
  end

  // Drop half range when every metric has crossed it
  always_comb begin
    all_msb = 1'b1;
    for (int s = 0; s < NSTATE; s++)
      all_msb = all_msb & pm_new[s][PM_W-1];
    for (int s = 0; s < NSTATE; s++) begin
      pm_norm[s] = pm_new[s];
      if (all_msb)
        pm_norm[s][PM_W-1] = 1'b0;
    end
  end

  // Frame control, metric/decision update and symbol count
  always_comb begin
    fsm_d   = fsm_q;
    pm_d    = pm_q;
    dec_d   = dec_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    accept  = bus.i_valid && (fsm_q == RUN || bus.i_start);
    if (bus.i_start) begin
      fsm_d = RUN;
      pm_d  = pm_init;
      cnt_d = '0;
    end
    if (accept) begin
      valid_d = 1'b1;
      for (int s = 0; s < NSTATE; s++) begin
        pm_d[s]  = pm_norm[s];
        dec_d[s] = dec_new[s];
      end
      if (bus.i_start)
        cnt_d = CNT_W'(1);
      else if (cnt_q != '1)
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      pm_q    <= pm_init;
      dec_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      pm_q    <= pm_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_decision = dec_q;
  assign bus.o_pm       = pm_q;
  assign bus.o_sym_cnt  = cnt_q;

`ifdef BEST_STATE_EN
  pm_t    tv [1:2*NSTATE-1];
  state_t ti [1:2*NSTATE-1];
  state_t best_q, best_d;

  // Argmin tree over the next metrics; left child wins ties
  always_comb begin
    for (int s = 0; s < NSTATE; s++) begin
      tv[NSTATE+s] = pm_norm[s];
      ti[NSTATE+s] = state_t'(s);
    end
    for (int k = NSTATE - 1; k >= 1; k--) begin
      if (tv[2*k+1] < tv[2*k]) begin
        tv[k] = tv[2*k+1];
        ti[k] = ti[2*k+1];
      end else begin
        tv[k] = tv[2*k];
        ti[k] = ti[2*k];
      end
    end
  end

  // Best state tracks the registered metrics
  always_comb begin
    best_d = best_q;
    if (bus.i_start)
      best_d = '0;
    if (accept)
      best_d = ti[1];
  end

  // Best-state register
  always_ff @(posedge clk) begin
    if (rst)
      best_q <= '0;
    else
      best_q <= best_d;
  end

  assign bus.o_best_state = best_q;
`else
  assign bus.o_best_state = '0;
`endif

endmodule

// File: tb/tb_acs_unit.sv
// Scoreboard bench for acs_unit against an unbounded-integer trellis.
// Directed vectors; monitor pops expectations on o_valid.
module tb_acs_unit;
  import viterbi_pkg::*;

  typedef struct packed {
    logic [31:0]             issue;
    logic [3:0]              tag;
    logic [255:0][31:0]      pm;
    logic [255:0][1:0]       dec;
    logic [15:0]             cnt;
    logic [7:0]              best;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   max_off = 0;

  acs_unit_if bus ();

  acs_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q[$];
  exp_t pe;
  exp_t me;
  int   mpm [256];
  int   mcnt = 0;
  bit   run = 1'b0;
  dist_t [NSTATE-1:0][RADIX-1:0] dv;

  task automatic chk(input string nm, input bit ok,
                     input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic model_init();
    for (int s = 0; s < 256; s++)
      mpm[s] = (s == 0) ? 0 : 256;
  endtask

  task automatic model_step();
    int nv [256];
    int bc, bp, sp, c, bi;
    for (int ns = 0; ns < 256; ns++) begin
      bc = 32'h7fffffff;
      bp = 0;
      for (int p = 0; p < 4; p++) begin
        sp = (p << 6) | (ns >> 2);
        c  = mpm[sp] + int'(dv[sp][ns & 3]);
        if (c < bc) begin
          bc = c;
          bp = p;
        end
      end
      nv[ns] = bc;
      pe.dec[ns] = 2'(bp);
    end
    bi = 0;
    for (int s = 0; s < 256; s++) begin
      if (nv[s] < nv[bi]) bi = s;
      pe.pm[s] = 32'(nv[s]);
      mpm[s] = nv[s];
    end
    pe.best = 8'(bi);
  endtask

  task automatic sym(input bit st, input bit v, input int tag);
    @(negedge clk);
    bus.i_start = st;
    bus.i_valid = v;
    bus.i_dist  = dv;
    if (st) begin
      model_init();
      mcnt = 0;
      run  = 1'b1;
    end
    if (v && run) begin
      model_step();
      if (mcnt != 65535) mcnt++;
      pe.cnt   = 16'(mcnt);
      pe.issue = 32'(cyc);
      pe.tag   = 4'(tag);
      q.push_back(pe);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      bus.i_valid = 1'b0;
    end
  endtask

  task automatic check_init(input string nm);
    int bad = -1;
    for (int s = 0; s < 256; s++) begin
      if (bus.o_pm[s] !== ((s == 0) ? 10'd0 : 10'd256)) bad = s;
      if (bus.o_decision[s] !== 2'd0) bad = s;
    end
    chk({nm, "_pm_dec"}, bad < 0, bad, -1);
    chk({nm, "_valid"}, bus.o_valid === 1'b0, bus.o_valid, 0);
    chk({nm, "_cnt"}, bus.o_sym_cnt === 16'd0, bus.o_sym_cnt, 0);
    chk({nm, "_best"}, bus.o_best_state === 8'd0, bus.o_best_state, 0);
  endtask

  int  m_off, m_bad, m_exb;
  bit  m_ok;

  always @(negedge clk) begin
    if (q.size() > 0 && cyc > int'(q[0].issue) + 1) begin
      chk("missing_valid", 1'b0, cyc, int'(q[0].issue) + 1);
      void'(q.pop_front());
    end
    if (bus.o_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 1'b0, 1, 0);
      end else begin
        me = q.pop_front();
        chk("latency", cyc == int'(me.issue) + 1, cyc - int'(me.issue), 1);
        m_bad = -1;
        for (int s = 0; s < 256; s++)
          if (bus.o_decision[s] !== me.dec[s]) m_bad = s;
        chk("decision", m_bad < 0, m_bad, -1);
        m_off = int'(me.pm[0]) - int'(bus.o_pm[0]);
        m_ok  = !$isunknown(bus.o_pm) && m_off >= 0 && (m_off % 512) == 0;
        m_bad = -1;
        for (int s = 0; s < 256; s++)
          if (int'(me.pm[s]) - int'(bus.o_pm[s]) != m_off) m_bad = s;
        chk("pm_offset", m_ok && m_bad < 0, m_off, m_bad);
        if (m_off > max_off) max_off = m_off;
        chk("sym_cnt", bus.o_sym_cnt === me.cnt, bus.o_sym_cnt, me.cnt);
`ifdef BEST_STATE_EN
        m_exb = int'(me.best);
`else
        m_exb = 0;
`endif
        chk("best_state", bus.o_best_state === 8'(m_exb), bus.o_best_state, m_exb);
        m_bad = -1;
        case (int'(me.tag))
          1: begin
            for (int s = 0; s < 256; s++) begin
              if (bus.o_pm[s] !== (((s >> 2) == 0) ? 10'd0 : 10'd256)) m_bad = s;
              if (bus.o_decision[s] !== 2'd0) m_bad = s;
            end
            chk("t1_first_symbol", m_bad < 0, m_bad, -1);
          end
          2: begin
            for (int s = 0; s < 256; s++)
              if (bus.o_decision[s] !== 2'd0) m_bad = s;
            chk("t2_tie_all_equal", m_bad < 0, m_bad, -1);
          end
          3: begin
            for (int s = 0; s < 256; s++)
              if (bus.o_decision[s] !== 2'd1) m_bad = s;
            chk("t2_tie_3112", m_bad < 0, m_bad, -1);
          end
          4: chk("t4_restart_cnt", bus.o_sym_cnt === 16'd1, bus.o_sym_cnt, 1);
          6: begin
            chk("t6_pm_final", bus.o_pm[8'h63] === 10'd0, bus.o_pm[8'h63], 0);
`ifdef BEST_STATE_EN
            chk("t6_best", bus.o_best_state === 8'h63, bus.o_best_state, 8'h63);
`endif
          end
          default: ;
        endcase
      end
    end
  end

  int tbl [4] = '{3, 1, 1, 2};
  int ins [12] = '{1, 1, 2, 2, 3, 0, 2, 1, 1, 2, 0, 3};
  int st;

  initial begin
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    dv = '0;
    bus.i_dist = dv;
    model_init();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_init("reset");

    dv = '1;
    sym(0, 1, 0);
    sym(0, 1, 0);
    idle(2);
    check_init("idle_ignore");

    dv = '0;
    sym(1, 0, 0);
    sym(0, 1, 1);
    sym(0, 1, 0);
    sym(0, 1, 0);
    sym(0, 1, 0);
    for (int s = 0; s < 256; s++)
      for (int j = 0; j < 4; j++)
        dv[s][j] = 3'd5;
    sym(0, 1, 2);
    for (int s = 0; s < 256; s++)
      for (int j = 0; j < 4; j++)
        dv[s][j] = dist_t'(tbl[s >> 6]);
    sym(0, 1, 3);

    for (int k = 0; k < 6; k++) begin
      for (int s = 0; s < 256; s++)
        for (int j = 0; j < 4; j++)
          dv[s][j] = dist_t'((s * 5 + j * 3 + k) % 8);
      sym(0, 1, 0);
    end
    sym(1, 1, 4);
    sym(0, 1, 0);
    sym(0, 1, 0);
    idle(1);

    dv = '1;
    dv[0][0] = 3'd1;
    sym(1, 1, 0);
    for (int i = 0; i < 2000; i++)
      sym(0, 1, 0);
    idle(3);
    chk("norm_fired", max_off >= 512, max_off, 512);

    for (int s = 0; s < 256; s++)
      for (int j = 0; j < 4; j++)
        dv[s][j] = dist_t'((s + 7 * j) % 8);
    sym(1, 0, 0);
    sym(0, 1, 0);
    sym(0, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_start = 1'b0;
    run = 1'b0;
    model_init();
    mcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    check_init("mid_rst");
    sym(0, 1, 0);
    sym(0, 1, 0);
    idle(2);
    check_init("idle_after_rst");

    sym(1, 0, 0);
    st = 0;
    for (int k = 0; k < 12; k++) begin
      dv = '1;
      dv[st][ins[k]] = 3'd0;
      sym(0, 1, (k == 11) ? 6 : 0);
      st = ((st << 2) | ins[k]) & 8'hFF;
    end
    idle(3);
    chk("drain", q.size() == 0, q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
